mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single data-memory (BRAM) port between load buffer issue and in-order store commit from the ROB.
// Grants one requester per cycle, drives the registered memory port, tracks the one in-flight load through the
// fixed read latency and returns load data with its ROB index to the ROB. Sits between load_buffer/ROB and data BRAM.
// PARAMETERS
// ROB_IX       2   ROB index MSB; index width is ROB_IX+1
// ADDR_W       10  word-address width of data BRAM
// MEM_LATENCY  2   cycles from mem_en_out sampled to mem_rdata_in valid; legal range >= 1
// PORTS
// clk_in          in   1         clock
// rst_in          in   1         asynchronous reset, active-low
// flush_in        in   1         pipeline flush (synchronous)
// ld_valid_in     in   1         load buffer has an issuable load
// ld_addr_in      in   32        byte address of load
// ld_rob_ix_in    in   ROB_IX+1  ROB index of load
// ld_read_out     out  1         load accepted this cycle (drives load buffer read_in)
// st_valid_in     in   1         ROB commits a store
// st_addr_in      in   32        byte address of store
// st_data_in      in   32        store data
// st_ready_out    out  1         store accepted this cycle
// mem_en_out      out  1         BRAM enable (registered)
// mem_we_out      out  1         BRAM write enable (registered)
// mem_addr_out    out  ADDR_W    word address = addr[ADDR_W+1:2] (registered)
// mem_wdata_out   out  32        write data (registered)
// mem_rdata_in    in   32        BRAM read data
// ld_result_valid_out out 1      one-cycle pulse: load data ready (registered)
// ld_result_out   out  32        load data
// ld_result_rob_ix_out out ROB_IX+1 ROB index of returned load
// BEHAVIOUR
// - Reset (rst_in low, async): state IDLE, prefer_load=0, drop=0, all outputs and registers 0.
// - States: IDLE, LOAD_WAIT. Handshakes ld_read_out / st_ready_out are combinational, only high in IDLE.
// - IDLE grant: only ld -> load; only st -> store; both -> load if prefer_load else store. No grant -> idle.
// - Load grant blocked when flush_in=1 (ld_read_out=0); store grant unaffected by flush (stores are committed).
// - prefer_load set on store grant, cleared on load grant (alternation under contention, no starvation).
// - Store grant cycle t: mem_en/we=1, addr, wdata at t+1 for one cycle; stay IDLE, next grant possible at t+1.
// - Load grant cycle t: latch rob_ix; mem_en=1, we=0, addr at t+1; enter LOAD_WAIT, counter=MEM_LATENCY.
// - LOAD_WAIT: no grants; counter decrements each cycle; at cycle t+1+MEM_LATENCY capture mem_rdata_in, go IDLE.
// - ld_result_valid_out pulses at t+2+MEM_LATENCY with data and latched rob_ix; new grant also allowed that cycle.
// - Result data/rob_ix hold their value until next capture; only the valid pulses.
// - Flush while in LOAD_WAIT (incl. capture cycle): set drop; capture cycle returns to IDLE, no valid pulse; drop cleared.
// - Flush coincident with result pulse: pulse not suppressed (ROB discards).
// - Flush in IDLE does not alter state or prefer_load.
// - Address bits [1:0] ignored (word accesses only); upper bits above ADDR_W+1 ignored.
// - At most one load outstanding; mem_en_out never high on two consecutive cycles for a load.
// TESTING
// - Lone load, L=2: ld_valid, addr 0x10, rob 3 at c0 -> ld_read c0; mem_en c1 addr 4 we 0; rdata 0xDEADBEEF at c3 -> result_valid c4, data 0xDEADBEEF, rob 3.
// - Three stores addr 0x0/0x4/0x8 at c0..c2 -> st_ready each cycle; mem_we pulses c1..c3, addr 0,1,2, wdata matches.
// - Both valid continuously from reset -> grants store, load, (3-cycle wait), store, load...; counts equal within 1.
// - Store arrives during LOAD_WAIT -> st_ready 0 until IDLE, granted in result-pulse cycle, mem_we next cycle.
// - flush_in one cycle in LOAD_WAIT -> no result_valid; store with flush in IDLE still written; load with flush not read.
// - rst_in low mid LOAD_WAIT -> outputs 0 immediately; after release no result_valid, IDLE grants lone load normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the load-buffer, ROB-store, BRAM and load-result signals of the data-memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline and BRAM.
interface mem_port_arbiter_if #(
    parameter int ROB_IX = 2,
    parameter int ADDR_W = 10
);
    // Load buffer issue
    logic              ld_valid_in;
    logic [31:0]       ld_addr_in;
    logic [ROB_IX:0]   ld_rob_ix_in;
    logic              ld_read_out;

    // ROB store commit
    logic              st_valid_in;
    logic [31:0]       st_addr_in;
    logic [31:0]       st_data_in;
    logic              st_ready_out;

    // Data BRAM port
    logic              mem_en_out;
    logic              mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [31:0]       mem_wdata_out;
    logic [31:0]       mem_rdata_in;

    // Load result back to the ROB
    logic              ld_result_valid_out;
    logic [31:0]       ld_result_out;
    logic [ROB_IX:0]   ld_result_rob_ix_out;

    modport slave (
        input  ld_valid_in, ld_addr_in, ld_rob_ix_in,
        output ld_read_out,
        input  st_valid_in, st_addr_in, st_data_in,
        output st_ready_out,
        output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
        input  mem_rdata_in,
        output ld_result_valid_out, ld_result_out, ld_result_rob_ix_out
    );

    modport master (
        output ld_valid_in, ld_addr_in, ld_rob_ix_in,
        input  ld_read_out,
        output st_valid_in, st_addr_in, st_data_in,
        input  st_ready_out,
        input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
        output mem_rdata_in,
        input  ld_result_valid_out, ld_result_out, ld_result_rob_ix_out
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single data-BRAM port between load issue and in-order store commit, tracks the one
// outstanding load through the fixed BRAM read latency and returns its data with the ROB index.
module mem_port_arbiter #(
    parameter int ROB_IX      = 2,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   flush_in,
    mem_port_arbiter_if.slave      bus
);

    localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t            state_q,       state_d;
    logic              prefer_load_q, prefer_load_d;
    logic              drop_q,        drop_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [ROB_IX:0]   rob_q,         rob_d;

    logic              mem_en_q,      mem_en_d;
    logic              mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [31:0]       mem_wdata_q,   mem_wdata_d;

    logic              res_valid_q,   res_valid_d;
    logic [31:0]       res_data_q,    res_data_d;
    logic [ROB_IX:0]   res_rob_q,     res_rob_d;

    logic              grant_ld;
    logic              grant_st;
    logic              ld_req;
    logic              st_req;

    // Only word-aligned accesses inside the BRAM range are meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ld_addr_in[1:0], bus.ld_addr_in[31:ADDR_W+2],
                                bus.st_addr_in[1:0], bus.st_addr_in[31:ADDR_W+2]};

    // A flush kills speculative loads before issue; committed stores always proceed.
    assign ld_req = bus.ld_valid_in && !flush_in;
    assign st_req = bus.st_valid_in;

    always_comb begin
        state_d       = state_q;
        prefer_load_d = prefer_load_q;
        drop_d        = drop_q;
        cnt_d         = cnt_q;
        rob_d         = rob_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        res_valid_d   = 1'b0;
        res_data_d    = res_data_q;
        res_rob_d     = res_rob_q;
        grant_ld      = 1'b0;
        grant_st      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ld_req && (!st_req || prefer_load_q)) begin
                    grant_ld = 1'b1;
                end else if (st_req) begin
                    grant_st = 1'b1;
                end

                if (grant_ld) begin
                    mem_en_d      = 1'b1;
                    mem_we_d      = 1'b0;
                    mem_addr_d    = bus.ld_addr_in[ADDR_W+1:2];
                    rob_d         = bus.ld_rob_ix_in;
                    cnt_d         = CNT_W'(MEM_LATENCY);
                    drop_d        = 1'b0;
                    prefer_load_d = 1'b0;
                    state_d       = LOAD_WAIT;
                end else if (grant_st) begin
                    mem_en_d      = 1'b1;
                    mem_we_d      = 1'b1;
                    mem_addr_d    = bus.st_addr_in[ADDR_W+1:2];
                    mem_wdata_d   = bus.st_data_in;
                    prefer_load_d = 1'b1;
                end
            end

            LOAD_WAIT: begin
                if (cnt_q == '0) begin
                    // Read data is valid this cycle; a flush seen at any point of the wait squashes it.
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!(drop_q || flush_in)) begin
                        res_valid_d = 1'b1;
                        res_data_d  = bus.mem_rdata_in;
                        res_rob_d   = rob_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (flush_in) begin
                        drop_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            prefer_load_q <= 1'b0;
            drop_q        <= 1'b0;
            cnt_q         <= '0;
            rob_q         <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rob_q     <= '0;
        end else begin
            state_q       <= state_d;
            prefer_load_q <= prefer_load_d;
            drop_q        <= drop_d;
            cnt_q         <= cnt_d;
            rob_q         <= rob_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_rob_q     <= res_rob_d;
        end
    end

    assign bus.ld_read_out          = grant_ld;
    assign bus.st_ready_out         = grant_st;
    assign bus.mem_en_out           = mem_en_q;
    assign bus.mem_we_out           = mem_we_q;
    assign bus.mem_addr_out         = mem_addr_q;
    assign bus.mem_wdata_out        = mem_wdata_q;
    assign bus.ld_result_valid_out  = res_valid_q;
    assign bus.ld_result_out        = res_data_q;
    assign bus.ld_result_rob_ix_out = res_rob_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a timeline model of port ownership,
// scheduled BRAM operations and scheduled load results.
module tb_mem_port_arbiter;
    localparam int ROB_IX = 2;
    localparam int ADDR_W = 10;
    localparam int L      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ROB_IX(ROB_IX), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(.ROB_IX(ROB_IX), .ADDR_W(ADDR_W), .MEM_LATENCY(L)) dut (
        .clk_in   (clk),
        .rst_in   (rst_n),
        .flush_in (flush),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: the port is owned by a load up to busy_until; operations are scheduled by cycle number.
    int              busy_until;
    int              cap_cyc;
    bit              prefer_load;
    bit              drop;
    logic [ROB_IX:0] fl_rob;
    logic [31:0]     exp_we    [int];
    logic [31:0]     exp_addr  [int];
    logic [31:0]     exp_wdata [int];
    logic [31:0]     exp_rdata [int];
    logic [31:0]     exp_rrob  [int];
    int              n_ld;
    int              n_st;
    bit              hold_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy_until  = -1;
        cap_cyc     = -1;
        prefer_load = 1'b0;
        drop        = 1'b0;
        fl_rob      = '0;
        exp_we.delete();
        exp_addr.delete();
        exp_wdata.delete();
        exp_rdata.delete();
        exp_rrob.delete();
    endtask

    task automatic clear_inputs();
        bus.ld_valid_in  = 1'b0;
        bus.ld_addr_in   = '0;
        bus.ld_rob_ix_in = '0;
        bus.st_valid_in  = 1'b0;
        bus.st_addr_in   = '0;
        bus.st_data_in   = '0;
        flush            = 1'b0;
    endtask

    // One clock cycle: check every output against the model, advance the model, cross the edge.
    task automatic step();
        bit gl;
        bit gs;
        bit idle;
        if (!hold_rdata) bus.mem_rdata_in = $urandom;
        #1;
        idle = (cyc > busy_until);
        gl = idle && bus.ld_valid_in && !flush && (!bus.st_valid_in || prefer_load);
        gs = idle && bus.st_valid_in && !gl;

        check("ld_read", {31'b0, bus.ld_read_out}, {31'b0, gl});
        check("st_ready", {31'b0, bus.st_ready_out}, {31'b0, gs});
        check("mem_en", {31'b0, bus.mem_en_out}, exp_we.exists(cyc) ? 32'd1 : 32'd0);
        if (exp_we.exists(cyc)) begin
            check("mem_we", {31'b0, bus.mem_we_out}, exp_we[cyc]);
            check("mem_addr", {{(32-ADDR_W){1'b0}}, bus.mem_addr_out}, exp_addr[cyc]);
            if (exp_we[cyc] == 32'd1) check("mem_wdata", bus.mem_wdata_out, exp_wdata[cyc]);
        end
        check("res_valid", {31'b0, bus.ld_result_valid_out}, exp_rdata.exists(cyc) ? 32'd1 : 32'd0);
        if (exp_rdata.exists(cyc)) begin
            check("res_data", bus.ld_result_out, exp_rdata[cyc]);
            check("res_rob", {{(31-ROB_IX){1'b0}}, bus.ld_result_rob_ix_out}, exp_rrob[cyc]);
        end

        if (gs) begin
            exp_we[cyc+1]    = 32'd1;
            exp_addr[cyc+1]  = (bus.st_addr_in >> 2) % (32'd1 << ADDR_W);
            exp_wdata[cyc+1] = bus.st_data_in;
            prefer_load      = 1'b1;
            n_st++;
        end
        if (gl) begin
            exp_we[cyc+1]   = 32'd0;
            exp_addr[cyc+1] = (bus.ld_addr_in >> 2) % (32'd1 << ADDR_W);
            busy_until      = cyc + 1 + L;
            cap_cyc         = busy_until;
            drop            = 1'b0;
            fl_rob          = bus.ld_rob_ix_in;
            prefer_load     = 1'b0;
            n_ld++;
        end
        if (!gl && flush && cyc <= busy_until) drop = 1'b1;
        if (cyc == cap_cyc && !drop) begin
            exp_rdata[cyc+1] = bus.mem_rdata_in;
            exp_rrob[cyc+1]  = {{(31-ROB_IX){1'b0}}, fl_rob};
        end
        if (cyc == cap_cyc) drop = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"}, {31'b0, bus.mem_en_out}, 32'd0);
        check({tag, "_mem_we"}, {31'b0, bus.mem_we_out}, 32'd0);
        check({tag, "_mem_addr"}, {{(32-ADDR_W){1'b0}}, bus.mem_addr_out}, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata_out, 32'd0);
        check({tag, "_res_valid"}, {31'b0, bus.ld_result_valid_out}, 32'd0);
        check({tag, "_res_data"}, bus.ld_result_out, 32'd0);
        check({tag, "_res_rob"}, {{(31-ROB_IX){1'b0}}, bus.ld_result_rob_ix_out}, 32'd0);
    endtask

    // Asserts reset between clock edges and checks outputs clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #2;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        hold_rdata = 1'b0;
        clear_inputs();
        bus.mem_rdata_in = '0;
        model_reset();
        n_ld = 0;
        n_st = 0;

        // Power-on reset
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        // Lone load: addr 0x10, rob 3, read data 0xDEADBEEF at c3
        bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h10; bus.ld_rob_ix_in = 3'd3;
        step();
        clear_inputs();
        check("lone_mem_addr", {{(32-ADDR_W){1'b0}}, bus.mem_addr_out}, 32'd4);
        step();
        step();
        hold_rdata = 1'b1;
        bus.mem_rdata_in = 32'hDEADBEEF;
        step();
        hold_rdata = 1'b0;
        check("lone_res_valid", {31'b0, bus.ld_result_valid_out}, 32'd1);
        check("lone_res_data", bus.ld_result_out, 32'hDEADBEEF);
        check("lone_res_rob", {29'b0, bus.ld_result_rob_ix_out}, 32'd3);
        idle_steps(2);

        // Three back-to-back stores to 0x0, 0x4, 0x8
        for (int i = 0; i < 3; i++) begin
            bus.st_valid_in = 1'b1;
            bus.st_addr_in  = 32'(i * 4);
            bus.st_data_in  = $urandom;
            step();
        end
        idle_steps(2);

        // Continuous contention from reset: store first, then strict alternation
        do_reset("rst_a");
        n_ld = 0;
        n_st = 0;
        for (int i = 0; i < 30; i++) begin
            bus.ld_valid_in  = 1'b1;
            bus.ld_addr_in   = $urandom;
            bus.ld_rob_ix_in = 3'($urandom_range(7));
            bus.st_valid_in  = 1'b1;
            bus.st_addr_in   = $urandom;
            bus.st_data_in   = $urandom;
            step();
        end
        check("fair_ld_nonzero", {31'b0, n_ld > 0}, 32'd1);
        check("fair_balance", {31'b0, (n_ld - n_st <= 1) && (n_st - n_ld <= 1)}, 32'd1);
        idle_steps(L + 2);

        // Store arriving while a load is outstanding
        bus.ld_valid_in = 1'b1; bus.ld_addr_in = $urandom; bus.ld_rob_ix_in = 3'd5;
        step();
        bus.ld_valid_in = 1'b0;
        bus.st_valid_in = 1'b1; bus.st_addr_in = 32'h0000_0ABC; bus.st_data_in = $urandom;
        for (int i = 0; i < L + 2; i++) step();
        idle_steps(2);

        // Flush during the load wait squashes the result
        bus.ld_valid_in = 1'b1; bus.ld_addr_in = $urandom; bus.ld_rob_ix_in = 3'd6;
        step();
        clear_inputs();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_steps(L + 1);

        // Flush on the capture cycle itself
        bus.ld_valid_in = 1'b1; bus.ld_addr_in = $urandom; bus.ld_rob_ix_in = 3'd2;
        step();
        clear_inputs();
        for (int i = 0; i < L; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_steps(2);

        // Flush in IDLE: store still written, load not read
        flush = 1'b1;
        bus.st_valid_in = 1'b1; bus.st_addr_in = 32'h0000_0100; bus.st_data_in = 32'hCAFE_F00D;
        step();
        bus.st_valid_in = 1'b0;
        bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h20; bus.ld_rob_ix_in = 3'd1;
        step();
        idle_steps(3);

        // Reset mid load wait, then a normal lone load
        bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h44; bus.ld_rob_ix_in = 3'd7;
        step();
        clear_inputs();
        step();
        do_reset("rst_mid");
        idle_steps(L + 3);
        bus.ld_valid_in = 1'b1; bus.ld_addr_in = 32'h0000_1008; bus.ld_rob_ix_in = 3'd4;
        step();
        idle_steps(L + 3);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            bus.ld_valid_in  = 1'($urandom_range(1));
            bus.ld_addr_in   = $urandom;
            bus.ld_rob_ix_in = 3'($urandom_range(7));
            bus.st_valid_in  = 1'($urandom_range(1));
            bus.st_addr_in   = $urandom;
            bus.st_data_in   = $urandom;
            flush            = ($urandom_range(9) == 0);
            step();
        end
        idle_steps(L + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
